core_bus_arbiter: RTL and testbench



---
 rtl/core_bus_pkg.sv | 19 +
 rtl/core_bus_arbiter_rr_arbiter.sv | 32 +++
 rtl/core_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_core_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
// Shared widths, opcodes and FSM state encoding for the core bus arbiter.
package core_bus_pkg;

    localparam int INSTR_W = 8;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;

    localparam logic [INSTR_W-1:0] INSTR_NOP   = 8'h00;
    localparam logic [INSTR_W-1:0] INSTR_WRITE = 8'h01;
    localparam logic [INSTR_W-1:0] INSTR_READ  = 8'h02;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/core_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr,
// wrapping modulo NUM_REQ. Produces a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    // Scan from the farthest position back to rr_ptr so the last hit is the first in order
    always_comb begin
        gnt_idx = '0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum   = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            w_sum   = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? (w_sum - (IDX_W+1)'(NUM_REQ)) : w_sum;
            w_pos   = w_sum[IDX_W-1:0];
            gnt_idx = req[w_pos] ? w_pos : gnt_idx;
        end
        gnt_valid = |req;
        gnt_oh    = {{(NUM_REQ-1){1'b0}}, gnt_valid} << gnt_idx;
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin owner of the shared core bus: issue pulse, read-latency wait, done.
// Optional address range rejection is enabled by defining CORE_BUS_ADDR_CHECK_EN.
module core_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter int                NUM_REQ      = 2,
    parameter int                READ_LATENCY = 2,
    parameter logic [ADDR_W-1:0] ADDR_LO      = 24'h000000,
    parameter logic [ADDR_W-1:0] ADDR_HI      = 24'hFFFFFF
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*INSTR_W-1:0]  req_instr,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          err,
    output logic [DATA_W-1:0]           rdata,
    output logic [INSTR_W-1:0]          instr_bus,
    output logic [ADDR_W-1:0]           addr_bus,
    output logic [DATA_W-1:0]           val_in_bus,
    input  logic [DATA_W-1:0]           val_out_bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt, r_done, w_done_nxt;
    logic [NUM_REQ-1:0] r_owner_oh, w_owner_oh_nxt;
    logic [IDX_W-1:0]   r_owner_idx, w_owner_idx_nxt, r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [INSTR_W-1:0] r_instr_bus, w_instr_nxt;
    logic [ADDR_W-1:0]  r_addr_bus, w_addr_nxt;
    logic [DATA_W-1:0]  r_val_in_bus, w_val_in_nxt, r_rdata, w_rdata_nxt;

    logic [NUM_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [INSTR_W-1:0] w_sel_instr;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    // A reversed range can never accept an address; flag it structurally only.
    if (ADDR_HI < ADDR_LO) begin : g_addr_range_reversed
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (r_rr_ptr),
        .gnt_oh    (w_pick_oh),
        .gnt_idx   (w_pick_idx),
        .gnt_valid (w_pick_valid)
    );

    assign w_sel_instr = req_instr[int'(w_pick_idx)*INSTR_W +: INSTR_W];
    assign w_sel_addr  = req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata[int'(w_pick_idx)*DATA_W +: DATA_W];

`ifdef CORE_BUS_ADDR_CHECK_EN
    logic               w_addr_ok;
    logic               r_rej, w_rej_nxt;
    logic [NUM_REQ-1:0] r_err, w_err_nxt;
    assign w_addr_ok = (w_sel_addr >= ADDR_LO) && (w_sel_addr <= ADDR_HI);
    assign err       = r_err;
`else
    assign err = '0;
`endif

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = '0;
        w_done_nxt      = '0;
        w_instr_nxt     = INSTR_NOP;
        w_addr_nxt      = r_addr_bus;
        w_val_in_nxt    = r_val_in_bus;
        w_rdata_nxt     = r_rdata;
        w_cnt_nxt       = r_cnt;
        w_owner_oh_nxt  = r_owner_oh;
        w_owner_idx_nxt = r_owner_idx;
        w_rr_ptr_nxt    = r_rr_ptr;
`ifdef CORE_BUS_ADDR_CHECK_EN
        w_rej_nxt       = r_rej;
        w_err_nxt       = '0;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_owner_oh_nxt  = w_pick_oh;
                    w_owner_idx_nxt = w_pick_idx;
                    w_addr_nxt      = w_sel_addr;
                    w_val_in_nxt    = w_sel_wdata;
                    w_gnt_nxt       = w_pick_oh;
`ifdef CORE_BUS_ADDR_CHECK_EN
                    if (w_addr_ok) begin
                        w_instr_nxt = w_sel_instr;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_rej_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end
`else
                    w_instr_nxt = w_sel_instr;
                    w_state_nxt = ISSUE;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (r_instr_bus == INSTR_READ) begin
                    w_cnt_nxt   = CNT_W'(READ_LATENCY - 1);
                    w_state_nxt = WAIT;
                end else begin
                    w_done_nxt  = r_owner_oh;
                    w_state_nxt = DONE;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_rdata_nxt = val_out_bus;
                    w_done_nxt  = r_owner_oh;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            DONE: begin
`ifdef CORE_BUS_ADDR_CHECK_EN
                // A rejected grant spends one extra DONE cycle so done lands a cycle after gnt
                if (r_rej) begin
                    w_rej_nxt  = 1'b0;
                    w_done_nxt = r_owner_oh;
                    w_err_nxt  = r_owner_oh;
                end else begin
                    w_rr_ptr_nxt = (r_owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner_idx + IDX_W'(1);
                    w_state_nxt  = IDLE;
                end
`else
                w_rr_ptr_nxt = (r_owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner_idx + IDX_W'(1);
                w_state_nxt  = IDLE;
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_done       <= '0;
            r_instr_bus  <= INSTR_NOP;
            r_addr_bus   <= '0;
            r_val_in_bus <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
            r_owner_oh   <= '0;
            r_owner_idx  <= '0;
            r_rr_ptr     <= '0;
`ifdef CORE_BUS_ADDR_CHECK_EN
            r_rej        <= 1'b0;
            r_err        <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_done       <= w_done_nxt;
            r_instr_bus  <= w_instr_nxt;
            r_addr_bus   <= w_addr_nxt;
            r_val_in_bus <= w_val_in_nxt;
            r_rdata      <= w_rdata_nxt;
            r_cnt        <= w_cnt_nxt;
            r_owner_oh   <= w_owner_oh_nxt;
            r_owner_idx  <= w_owner_idx_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
`ifdef CORE_BUS_ADDR_CHECK_EN
            r_rej        <= w_rej_nxt;
            r_err        <= w_err_nxt;
`endif
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign instr_bus  = r_instr_bus;
    assign addr_bus   = r_addr_bus;
    assign val_in_bus = r_val_in_bus;
    assign rdata      = r_rdata;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed self-checking bench for core_bus_arbiter (NUM_REQ=2, READ_LATENCY=2).
module tb_core_bus_arbiter;
    import core_bus_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int RL      = 2;
    localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;
`ifdef CORE_BUS_ADDR_CHECK_EN
    localparam logic [23:0] TB_ADDR_HI = 24'h000002;
`else
    localparam logic [23:0] TB_ADDR_HI = 24'hFFFFFF;
`endif

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_instr;
    logic [NUM_REQ*24-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]   gnt, done, err;
    logic [31:0]          rdata, val_in_bus, val_out_bus;
    logic [7:0]           instr_bus;
    logic [23:0]          addr_bus;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    core_bus_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .READ_LATENCY (RL),
        .ADDR_LO      (24'h000000),
        .ADDR_HI      (TB_ADDR_HI)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .req_instr   (req_instr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .instr_bus   (instr_bus),
        .addr_bus    (addr_bus),
        .val_in_bus  (val_in_bus),
        .val_out_bus (val_out_bus)
    );

    task automatic drive(input int i, input logic [7:0] op, input logic [23:0] a, input logic [31:0] d);
        req_instr[i*8 +: 8]   = op;
        req_addr[i*24 +: 24]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", done); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (instr_bus !== 8'h00) begin errors++; $display("FAIL reset_instr: got %h expected 00", instr_bus); end
        checks++; if (addr_bus !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", addr_bus); end
        checks++; if (val_in_bus !== 32'h0) begin errors++; $display("FAIL reset_val_in: got %h expected 0", val_in_bus); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_write();
        drive(0, INSTR_WRITE, 24'h000001, 32'h12345678);
        req = 2'b01;
        @(negedge clock);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b expected 01", gnt); end
        checks++; if (instr_bus !== 8'h01) begin errors++; $display("FAIL wr_instr: got %h expected 01", instr_bus); end
        checks++; if (addr_bus !== 24'h000001) begin errors++; $display("FAIL wr_addr: got %h expected 000001", addr_bus); end
        checks++; if (val_in_bus !== 32'h12345678) begin errors++; $display("FAIL wr_val_in: got %h expected 12345678", val_in_bus); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL wr_early_done: got %b expected 00", done); end
        @(negedge clock);
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL wr_done: got %b expected 01", done); end
        checks++; if (instr_bus !== 8'h00) begin errors++; $display("FAIL wr_nop: got %h expected 00", instr_bus); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL wr_gnt_pulse: got %b expected 00", gnt); end
        req = 2'b00;
        @(negedge clock);
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL wr_done_pulse: got %b expected 00", done); end
        checks++; if (addr_bus !== 24'h000001) begin errors++; $display("FAIL wr_addr_hold: got %h expected 000001", addr_bus); end
    endtask

    task automatic test_read();
        drive(1, INSTR_READ, 24'h000002, 32'h0);
        req = 2'b10;
        @(negedge clock);
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rd_gnt: got %b expected 10", gnt); end
        checks++; if (instr_bus !== 8'h02) begin errors++; $display("FAIL rd_instr: got %h expected 02", instr_bus); end
        @(negedge clock);
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL rd_done_n2: got %b expected 00", done); end
        val_out_bus = 32'hCAFEF00D;
        @(negedge clock);
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL rd_done_n3: got %b expected 00", done); end
        @(negedge clock);
        val_out_bus = GARBAGE;
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL rd_done: got %b expected 10", done); end
        checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_rdata: got %h expected cafef00d", rdata); end
        req = 2'b00;
        @(negedge clock);
        checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_rdata_hold: got %h expected cafef00d", rdata); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [23:0] exp_a;
        drive(0, INSTR_WRITE, 24'h000000, 32'hAAAA0000);
        drive(1, INSTR_WRITE, 24'h000001, 32'hBBBB1111);
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (t % 2 == 0) ? 24'h000000 : 24'h000001;
            @(negedge clock);
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", t, gnt, exp_g); end
            checks++; if (addr_bus !== exp_a) begin errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", t, addr_bus, exp_a); end
            @(negedge clock);
            checks++; if (done !== exp_g) begin errors++; $display("FAIL rr_done[%0d]: got %b expected %b", t, done, exp_g); end
            @(negedge clock);
            checks++; if ({gnt, done} !== 4'b0000) begin errors++; $display("FAIL rr_gap[%0d]: got gnt=%b done=%b expected 00/00", t, gnt, done); end
            if (t == 3) req = 2'b00;
        end
        @(negedge clock);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rr_no_extra: got %b expected 00", gnt); end
    endtask

    task automatic test_unknown_opcode();
        drive(1, 8'h7E, 24'h000002, 32'h0BADCAFE);
        req = 2'b10;
        @(negedge clock);
        checks++; if (instr_bus !== 8'h7E) begin errors++; $display("FAIL unk_instr: got %h expected 7e", instr_bus); end
        @(negedge clock);
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL unk_done: got %b expected 10", done); end
        req = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_reset_abort();
        drive(1, INSTR_READ, 24'h000002, 32'h0);
        req = 2'b10;
        @(negedge clock);
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL abort_gnt: got %b expected 10", gnt); end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", rdata); end
        checks++; if (addr_bus !== 24'h0) begin errors++; $display("FAIL abort_addr: got %h expected 0", addr_bus); end
        checks++; if (instr_bus !== 8'h00) begin errors++; $display("FAIL abort_instr: got %h expected 00", instr_bus); end
        req = 2'b00;
        repeat (3) begin
            @(negedge clock);
            checks++; if (done !== 2'b00) begin errors++; $display("FAIL abort_no_done: got %b expected 00", done); end
        end
        reset_n = 1'b1;
        @(negedge clock);
        drive(1, INSTR_WRITE, 24'h000001, 32'h55AA55AA);
        req = 2'b10;
        @(negedge clock);
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL post_reset_gnt: got %b expected 10", gnt); end
        @(negedge clock);
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL post_reset_done: got %b expected 10", done); end
        req = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_drop_after_gnt();
        drive(0, INSTR_READ, 24'h000000, 32'h0);
        req = 2'b01;
        @(negedge clock);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL drop_gnt: got %b expected 01", gnt); end
        req = 2'b00;
        drive(0, INSTR_WRITE, 24'hFFFFFF, 32'h0);
        @(negedge clock);
        checks++; if (addr_bus !== 24'h000000) begin errors++; $display("FAIL drop_addr_latched: got %h expected 000000", addr_bus); end
        val_out_bus = 32'h5A5AA5A5;
        @(negedge clock);
        @(negedge clock);
        val_out_bus = GARBAGE;
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL drop_done: got %b expected 01", done); end
        checks++; if (rdata !== 32'h5A5AA5A5) begin errors++; $display("FAIL drop_rdata: got %h expected 5a5aa5a5", rdata); end
        @(negedge clock);
    endtask

    task automatic test_addr_check();
        drive(0, INSTR_READ, 24'h000005, 32'h0);
        req = 2'b01;
        @(negedge clock);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL ac_gnt: got %b expected 01", gnt); end
`ifdef CORE_BUS_ADDR_CHECK_EN
        checks++; if (instr_bus !== 8'h00) begin errors++; $display("FAIL ac_instr_n1: got %h expected 00", instr_bus); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL ac_early_done: got %b expected 00", done); end
        @(negedge clock);
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL ac_done: got %b expected 01", done); end
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL ac_err: got %b expected 01", err); end
        checks++; if (instr_bus !== 8'h00) begin errors++; $display("FAIL ac_instr_n2: got %h expected 00", instr_bus); end
        checks++; if (rdata !== 32'h5A5AA5A5) begin errors++; $display("FAIL ac_rdata: got %h expected 5a5aa5a5", rdata); end
        req = 2'b00;
        @(negedge clock);
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL ac_err_pulse: got %b expected 00", err); end
`else
        checks++; if (instr_bus !== 8'h02) begin errors++; $display("FAIL ac_instr: got %h expected 02", instr_bus); end
        @(negedge clock);
        val_out_bus = 32'h0F0F0F0F;
        @(negedge clock);
        @(negedge clock);
        val_out_bus = GARBAGE;
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL ac_done: got %b expected 01", done); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL ac_err: got %b expected 00", err); end
        checks++; if (rdata !== 32'h0F0F0F0F) begin errors++; $display("FAIL ac_rdata: got %h expected 0f0f0f0f", rdata); end
        req = 2'b00;
        @(negedge clock);
`endif
    endtask

    initial begin
        reset_n     = 1'b0;
        req         = '0;
        req_instr   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        val_out_bus = GARBAGE;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_unknown_opcode();
        test_reset_abort();
        test_drop_after_gnt();
        test_addr_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
